sprite_motion_ctrl: RTL and testbench

//  Upstream stage of the sprite renderer: owns the 40x40 sprite's screen position and visibility.

---
 rtl/sprite_motion_ctrl_pkg.sv | 25 ++
 rtl/sprite_motion_ctrl_axis_stepper.sv | 46 ++++
 rtl/sprite_motion_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared screen/sprite geometry, datapath widths and FSM state encoding for the sprite motion block.
package sprite_motion_ctrl_pkg;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned SPRITE_WID = 40;
  localparam int unsigned SPRITE_HGT = 40;

  // Largest legal top-left coordinate per axis
  localparam int unsigned X_MAX = SCREEN_W - SPRITE_WID;
  localparam int unsigned Y_MAX = SCREEN_H - SPRITE_HGT;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned D_W    = 3;
  localparam int unsigned CALC_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_BLINK  = 2'd3
  } state_e;

endpackage

// File: rtl/sprite_motion_ctrl_axis_stepper.sv
// One-axis add/clamp/flip datapath: computes next position and direction for a single motion step.
module sprite_motion_ctrl_axis_stepper
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int unsigned MAX = 600,
  parameter int unsigned W   = 10
) (
  input  logic [W-1:0]   pos,
  input  logic           dir,        // 0 = increasing, 1 = decreasing
  input  logic [D_W-1:0] d,
  input  logic           step,
  output logic [W-1:0]   pos_next_c,
  output logic           dir_next_c,
  output logic           hit_c
);

  logic [CALC_W-1:0] sum;

  // Step the axis in its current direction, clamping at the wall and reversing on contact
  always_comb begin
    pos_next_c = pos;
    dir_next_c = dir;
    hit_c      = 1'b0;
    sum        = CALC_W'(pos) + CALC_W'(d);
    if (step && (d != '0)) begin
      if (!dir) begin
        if (sum >= CALC_W'(MAX)) begin
          pos_next_c = W'(MAX);
          dir_next_c = 1'b1;
          hit_c      = 1'b1;
        end else begin
          pos_next_c = W'(sum);
        end
      end else begin
        if (CALC_W'(d) >= CALC_W'(pos)) begin
          pos_next_c = '0;
          dir_next_c = 1'b0;
          hit_c      = 1'b1;
        end else begin
          pos_next_c = pos - W'(d);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position/visibility controller: frame-divided motion, wall bounce and post-bounce blink.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int unsigned START_X         = 300,
  parameter int unsigned START_Y         = 220,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned BLINK_FRAMES    = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           FRAME_TICK,
  input  logic           START,
  input  logic           PAUSE,
  input  logic [D_W-1:0] DX,
  input  logic [D_W-1:0] DY,
  output logic [X_W-1:0] SPRITE_ORIGIN_OFFSET_X,
  output logic [Y_W-1:0] SPRITE_ORIGIN_OFFSET_Y,
  output logic           VISIBLE,
  output logic           BOUNCE,
  output logic [1:0]     STATE
);

  localparam int unsigned DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  state_e           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             dir_x_q, dir_x_d;
  logic             dir_y_q, dir_y_d;
  logic             vis_q, vis_d;
  logic             bounce_q, bounce_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BLK_W-1:0] blink_q, blink_d;

  logic             moving_c;
  logic             div_wrap_c;
  logic             step_c;
  logic [X_W-1:0]   x_next_c;
  logic [Y_W-1:0]   y_next_c;
  logic             dir_x_next_c, dir_y_next_c;
  logic             hit_x_c, hit_y_c;

  assign moving_c   = (state_q == ST_RUN) || (state_q == ST_BLINK);
  assign div_wrap_c = (div_q == DIV_W'(FRAMES_PER_STEP - 1));
  assign step_c     = moving_c && FRAME_TICK && !PAUSE && !START && div_wrap_c;

  sprite_motion_ctrl_axis_stepper #(.MAX(X_MAX), .W(X_W)) u_step_x (
    .pos        (x_q),
    .dir        (dir_x_q),
    .d          (DX),
    .step       (step_c),
    .pos_next_c (x_next_c),
    .dir_next_c (dir_x_next_c),
    .hit_c      (hit_x_c)
  );

  sprite_motion_ctrl_axis_stepper #(.MAX(Y_MAX), .W(Y_W)) u_step_y (
    .pos        (y_q),
    .dir        (dir_y_q),
    .d          (DY),
    .step       (step_c),
    .pos_next_c (y_next_c),
    .dir_next_c (dir_y_next_c),
    .hit_c      (hit_y_c)
  );

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      x_q      <= X_W'(START_X);
      y_q      <= Y_W'(START_Y);
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      vis_q    <= 1'b0;
      bounce_q <= 1'b0;
      div_q    <= '0;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      vis_q    <= vis_d;
      bounce_q <= bounce_d;
      div_q    <= div_d;
      blink_q  <= blink_d;
    end
  end

  // Next-state logic: launch, pause, frame-divided stepping and blink countdown
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    vis_d    = vis_q;
    bounce_d = 1'b0;
    div_d    = div_q;
    blink_d  = blink_q;

    if (START) begin
      state_d = ST_RUN;
      x_d     = X_W'(START_X);
      y_d     = Y_W'(START_Y);
      dir_x_d = 1'b0;
      dir_y_d = 1'b0;
      vis_d   = 1'b1;
      div_d   = '0;
      blink_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_PAUSED: begin
          if (!PAUSE) begin
            state_d = ST_RUN;
            vis_d   = 1'b1;
          end
        end
        ST_RUN, ST_BLINK: begin
          if (PAUSE) begin
            state_d = ST_PAUSED;
            vis_d   = 1'b1;
          end else if (FRAME_TICK) begin
            div_d   = div_wrap_c ? '0 : div_q + DIV_W'(1);
            x_d     = x_next_c;
            y_d     = y_next_c;
            dir_x_d = dir_x_next_c;
            dir_y_d = dir_y_next_c;
            if (state_q == ST_BLINK) begin
              vis_d = !vis_q;
            end
            if (hit_x_c || hit_y_c) begin
              bounce_d = 1'b1;
              blink_d  = BLK_W'(BLINK_FRAMES);
              state_d  = ST_BLINK;
            end else if (state_q == ST_BLINK) begin
              if (blink_q <= BLK_W'(1)) begin
                blink_d = '0;
                state_d = ST_RUN;
                vis_d   = 1'b1;
              end else begin
                blink_d = blink_q - BLK_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign SPRITE_ORIGIN_OFFSET_X = x_q;
  assign SPRITE_ORIGIN_OFFSET_Y = y_q;
  assign VISIBLE                = vis_q;
  assign BOUNCE                 = bounce_q;
  assign STATE                  = state_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (1 and 3 frames per step) against a frame-level model.
module tb_sprite_motion_ctrl;

  localparam int SX = 300;
  localparam int SY = 220;
  localparam int MAXX = 600;
  localparam int MAXY = 440;
  localparam int BF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, frame_tick, start, pause;
  logic [2:0] dx, dy;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic       vis0, vis1, b0, b1;
  logic [1:0] st0, st1;

  sprite_motion_ctrl #(.START_X(SX), .START_Y(SY), .FRAMES_PER_STEP(1), .BLINK_FRAMES(BF)) dut0 (
    .CLK(clk), .RESET(reset), .FRAME_TICK(frame_tick), .START(start), .PAUSE(pause),
    .DX(dx), .DY(dy),
    .SPRITE_ORIGIN_OFFSET_X(x0), .SPRITE_ORIGIN_OFFSET_Y(y0),
    .VISIBLE(vis0), .BOUNCE(b0), .STATE(st0)
  );

  sprite_motion_ctrl #(.START_X(SX), .START_Y(SY), .FRAMES_PER_STEP(3), .BLINK_FRAMES(BF)) dut1 (
    .CLK(clk), .RESET(reset), .FRAME_TICK(frame_tick), .START(start), .PAUSE(pause),
    .DX(dx), .DY(dy),
    .SPRITE_ORIGIN_OFFSET_X(x1), .SPRITE_ORIGIN_OFFSET_Y(y1),
    .VISIBLE(vis1), .BOUNCE(b1), .STATE(st1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state per instance (velocity sign kept as +1/-1)
  int fps[2] = '{1, 3};
  int m_x[2], m_y[2], m_sx[2], m_sy[2], m_vis[2], m_b[2], m_st[2], m_div[2], m_blink[2];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic move(inout int p, inout int s, input int d, input int mx, inout bit hit);
    int n;
    if (d == 0) return;
    n = p + s * d;
    if (n >= mx) begin
      p = mx; s = -1; hit = 1'b1;
    end else if (n <= 0) begin
      p = 0; s = 1; hit = 1'b1;
    end else begin
      p = n;
    end
  endtask

  task automatic model_clock(input int k);
    bit hit;
    bit was_blink;
    hit = 1'b0;
    if (reset) begin
      m_x[k] = SX; m_y[k] = SY; m_sx[k] = 1; m_sy[k] = 1;
      m_vis[k] = 0; m_b[k] = 0; m_st[k] = 0; m_div[k] = 0; m_blink[k] = 0;
      return;
    end
    m_b[k] = 0;
    if (start) begin
      m_x[k] = SX; m_y[k] = SY; m_sx[k] = 1; m_sy[k] = 1;
      m_vis[k] = 1; m_st[k] = 1; m_div[k] = 0; m_blink[k] = 0;
      return;
    end
    if (m_st[k] == 0) return;
    if (m_st[k] == 2) begin
      if (!pause) begin m_st[k] = 1; m_vis[k] = 1; end
      return;
    end
    if (pause) begin
      m_st[k] = 2; m_vis[k] = 1;
      return;
    end
    if (!frame_tick) return;
    m_div[k] = (m_div[k] + 1) % fps[k];
    if (m_div[k] == 0) begin
      move(m_x[k], m_sx[k], int'(dx), MAXX, hit);
      move(m_y[k], m_sy[k], int'(dy), MAXY, hit);
    end
    was_blink = (m_st[k] == 3);
    if (was_blink) m_vis[k] = 1 - m_vis[k];
    if (hit) begin
      m_b[k] = 1; m_blink[k] = BF; m_st[k] = 3;
    end else if (was_blink) begin
      m_blink[k]--;
      if (m_blink[k] == 0) begin m_st[k] = 1; m_vis[k] = 1; end
    end
  endtask

  task automatic check_all();
    check("x0", int'(x0), m_x[0]);
    check("y0", int'(y0), m_y[0]);
    check("vis0", int'(vis0), m_vis[0]);
    check("bounce0", int'(b0), m_b[0]);
    check("state0", int'(st0), m_st[0]);
    check("x1", int'(x1), m_x[1]);
    check("y1", int'(y1), m_y[1]);
    check("vis1", int'(vis1), m_vis[1]);
    check("bounce1", int'(b1), m_b[1]);
    check("state1", int'(st1), m_st[1]);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic cycle();
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
    check_all();
  endtask

  task automatic frame(input int gap, input bit with_start);
    frame_tick = 1'b1;
    start      = with_start;
    cycle();
    frame_tick = 1'b0;
    start      = 1'b0;
    repeat (gap) cycle();
  endtask

  initial begin
    bit reached;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; dx = 3'd0; dy = 3'd0;
    repeat (3) cycle();
    reset = 1'b0;

    // No START: sprite stays parked and hidden
    repeat (5) frame(2, 1'b0);
    check("idle_x", int'(x0), SX);
    check("idle_y", int'(y0), SY);
    check("idle_vis", int'(vis0), 0);
    check("idle_state", int'(st0), 0);

    // Launch and move ten frames
    start = 1'b1;
    cycle();
    start = 1'b0;
    dx = 3'd4; dy = 3'd2;
    repeat (10) frame(2, 1'b0);
    check("run_x0", int'(x0), 340);
    check("run_y0", int'(y0), 240);
    check("run_vis0", int'(vis0), 1);
    check("run_x1", int'(x1), 312);
    check("run_y1", int'(y1), 226);

    // Randomized frames: speed changes, pause bursts, relaunches and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) dx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dy = 3'($urandom_range(0, 7));
      if (!pause && $urandom_range(0, 23) == 0) pause = 1'b1;
      else if (pause && $urandom_range(0, 3) == 0) pause = 1'b0;
      frame(int'($urandom_range(1, 4)), ($urandom_range(0, 99) == 0));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
      end
    end

    // Drive instance 0 into a blink, then relaunch on a frame tick
    pause = 1'b0; dx = 3'd7; dy = 3'd7;
    start = 1'b1;
    cycle();
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      frame(2, 1'b0);
      if (m_st[0] == 3) reached = 1'b1;
    end
    check("blink_reached", int'(reached), 1);
    frame(2, 1'b0);
    frame_tick = 1'b1;
    start = 1'b1;
    cycle();
    frame_tick = 1'b0;
    start = 1'b0;
    check("restart_x", int'(x0), SX);
    check("restart_y", int'(y0), SY);
    check("restart_state", int'(st0), 1);
    check("restart_vis", int'(vis0), 1);

    // Reset in the middle of motion
    repeat (4) frame(2, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_x", int'(x0), SX);
    check("rst_y", int'(y0), SY);
    check("rst_vis", int'(vis0), 0);
    check("rst_bounce", int'(b0), 0);
    check("rst_state", int'(st0), 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
